// File: rtl/ps2_key_receiver_pkg.sv
// Shared definitions for the PS/2 keyboard receiver and the bus logic that consumes its bytes.
package ps2_key_receiver_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_e;

    localparam int unsigned PS2_FRAME_BITS = 11;

    // Top nibble of the bus address that selects the keyboard read path.
    localparam logic [3:0] KEY_REGION = 4'hD;

endpackage

// File: rtl/ps2_key_receiver_key_fifo.sv
// Synchronous show-ahead FIFO: head always shows the oldest entry, zero when empty.
module key_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_en;
    logic             rd_en;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign rd_en = pop && !empty;
    // A pop on a full FIFO frees the slot the incoming byte lands in.
    assign wr_en = push && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    assign head = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard frame receiver: synchronises the pins, decodes 11-bit frames and queues scan codes.
module ps2_key_receiver
    import ps2_key_receiver_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       key_pop,
    output logic [7:0] key_code,
    output logic       key_ready,
    output logic       frame_err,
    output logic       overflow
);
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic         ps2_clk_s1_q, ps2_clk_s2_q, ps2_clk_s3_q;
    logic         ps2_data_s1_q, ps2_data_s2_q;
    logic         fall;
    logic         bit_in;

    frame_state_e state_q, state_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   shift_q, shift_d;
    logic         parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic         frame_err_q, frame_err_d;
    logic         overflow_q, overflow_d;
    logic         push;
    logic         fifo_full;
    logic         fifo_empty;

    // Idle PS/2 lines float high, so the synchronisers reset to 1 to avoid a phantom edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps2_clk_s1_q  <= 1'b1;
            ps2_clk_s2_q  <= 1'b1;
            ps2_clk_s3_q  <= 1'b1;
            ps2_data_s1_q <= 1'b1;
            ps2_data_s2_q <= 1'b1;
        end else begin
            ps2_clk_s1_q  <= ps2_clk;
            ps2_clk_s2_q  <= ps2_clk_s1_q;
            ps2_clk_s3_q  <= ps2_clk_s2_q;
            ps2_data_s1_q <= ps2_data;
            ps2_data_s2_q <= ps2_data_s1_q;
        end
    end

    assign fall   = ps2_clk_s3_q && !ps2_clk_s2_q;
    assign bit_in = ps2_data_s2_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        tmo_d       = tmo_q;
        frame_err_d = 1'b0;
        push        = 1'b0;

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (fall && !bit_in) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d   = {bit_in, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    parity_d = bit_in;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (bit_in && ((^shift_q) ^ parity_q)) begin
                        push = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A stalled mid-frame transfer is abandoned silently.
        if (state_q != IDLE) begin
            if (fall) begin
                tmo_d = '0;
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                tmo_d   = '0;
                state_d = IDLE;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        overflow_d = overflow_q || (push && fifo_full && !key_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_key_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shift_q),
        .pop       (key_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (key_code)
    );

    assign key_ready = !fifo_empty;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule
